vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_pix_ce  in  1  pixel-clock enable; counters advance only on cycles where it is high.
REQ-008 o_fb_addr  out  17  framebuffer read address, 320x240 words, row-major.
REQ-009 i_fb_pixel  in  12  framebuffer read data {R4,G4,B4}, valid exactly one i_clk after o_fb_addr.
REQ-010 o_hsync, o_vsync  out  1 each  sync outputs, active-low.
REQ-011 o_r, o_g, o_b  out  4 each  colour outputs.
REQ-012 o_active  out  1  high while o_r/o_g/o_b carry a visible pixel.
REQ-013 o_frame_done  out  1  single-i_clk pulse at the start of vertical blanking, used for buffer swap.

Function
REQ-014 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters, 800) on each i_pix_ce, then wrap to 0.
REQ-015 v_cnt SHALL increment on the i_pix_ce where h_cnt wraps, counting 0..V_TOTAL-1 (525), then wrap to 0.
REQ-016 With i_pix_ce low, both counters and all pipeline contents SHALL hold.
REQ-017 Raw hsync SHALL be low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
REQ-018 Raw vsync SHALL be low for v_cnt in 490..491.
REQ-019 Raw active SHALL equal (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-020 The block SHALL apply 2x pixel doubling: o_fb_addr = (v_cnt>>1)*320 + (h_cnt>>1) during active.
REQ-021 The address SHALL be computed without a multiplier: a row-base register is cleared at v_cnt wrap and incremented by 320 at the end of each odd active line.
REQ-022 During blanking, o_fb_addr SHALL hold its last active value.
REQ-023 o_fb_addr SHALL be registered, one i_pix_ce-stage behind the counters.
REQ-024 The colour output registers SHALL capture i_fb_pixel one stage later.
REQ-025 hsync, vsync and active SHALL be delayed through a matching 2-stage shift, advancing on i_pix_ce, so all outputs stay mutually aligned.
REQ-026 Total latency from a counter value to its outputs SHALL be exactly 2 i_pix_ce events.
REQ-027 When the delayed active is 0, o_r/o_g/o_b SHALL be driven to 0.
REQ-028 o_frame_done SHALL pulse for exactly one i_clk when the delayed v_cnt first equals V_ACTIVE at h=0, i.e. once per frame.
REQ-029 The block SHALL function for any i_pix_ce duty, including i_pix_ce held constantly high.

Reset
REQ-030 On assertion of i_rst_n (low), immediately and regardless of i_clk, the block SHALL clear h_cnt, v_cnt, row base, o_fb_addr and the colour outputs to 0.
REQ-031 During reset, o_hsync and o_vsync SHALL be 1, o_active 0 and o_frame_done 0; pipeline sync stages reset to the inactive level.
REQ-032 After deassertion, the first i_pix_ce SHALL start at h=0, v=0; a reset mid-frame restarts the frame with no partial o_frame_done.

Structure
REQ-033 Timing defaults, H_TOTAL/V_TOTAL derivation, FB_W=320, FB_H=240 and a 12-bit pixel typedef SHALL live in package vga_pkg.
REQ-034 Counters and raw sync/active generation SHALL be one sub-module, vga_timing.
REQ-035 The address pipeline and output registers SHALL remain in vga_scanout.

Verification
REQ-036 i_pix_ce constantly high, one frame -> 525 hsync pulses each 96 pix_ce wide at 800-pix_ce period; vsync low for exactly 2 lines (1600 pix_ce); 640x480 = 307200 cycles with o_active high.
REQ-037 Framebuffer model returning addr[11:0] -> first active pixels carry addrs 0,0,1,1,...; line 1 repeats line 0; line 2 starts at 320; last active pixel (639,479) = 76799; outputs 2 pix_ce after counter.
REQ-038 i_pix_ce high one cycle in four -> same pixel sequence and sync widths scaled 4x in i_clk; outputs hold between enables.
REQ-039 Blanking with i_fb_pixel = 12'hFFF -> o_r/o_g/o_b = 0 whenever o_active = 0.
REQ-040 o_frame_done count over 3 frames = 3, each 1 i_clk wide, coincident with the first blanking line.
REQ-041 Assert i_rst_n low asynchronously at v=200 -> outputs reach reset values before the next i_clk edge; after release the frame restarts at address 0 and the next o_frame_done occurs 480 lines later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, framebuffer geometry and pixel/address types.
package vga_pkg;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    localparam int FB_W  = 320;
    localparam int FB_H  = 240;
    localparam int FB_AW = 17;

    typedef logic [11:0]      pixel_t;
    typedef logic [FB_AW-1:0] fb_addr_t;

    // Counter width able to hold 0..total-1.
    function automatic int cnt_width(int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout engine (master) and the pixel store (slave).
interface vga_scanout_if;
    import vga_pkg::*;

    fb_addr_t o_fb_addr;
    pixel_t   i_fb_pixel;

    modport master (output o_fb_addr, input  i_fb_pixel);
    modport slave  (input  o_fb_addr, output i_fb_pixel);
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical counters with raw (undelayed) sync, active and frame-position flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    localparam int HW      = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pix_ce,
    output logic [HW-2:0] o_h_pair,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic          o_blank_start,
    output logic          o_row_adv,
    output logic          o_frame_wrap
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VW      = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_M1 = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    assign o_h_pair      = h_cnt[HW-1:1];
    assign o_hsync       = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    assign o_vsync       = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
    assign o_active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign o_blank_start = (h_cnt == '0) && (v_cnt == V_ACT);
    // Row base moves on after the second line of each doubled pair.
    assign o_row_adv     = (h_cnt == H_ACT_M1) && v_cnt[0] && (v_cnt < V_ACT);
    assign o_frame_wrap  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
endmodule

// File: rtl/vga_scanout.sv
// 2x pixel-doubled VGA scanout: address stage, framebuffer read, then aligned colour/sync outputs.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pix_ce,
    vga_scanout_if.master fb,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic [3:0]    o_r,
    output logic [3:0]    o_g,
    output logic [3:0]    o_b,
    output logic          o_active,
    output logic          o_frame_done
);
    localparam int HW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);

    logic [HW-2:0] h_pair;
    logic          raw_hsync, raw_vsync, raw_active, raw_blank_start;
    logic          row_adv, frame_wrap;
    fb_addr_t      row_base, fb_addr;
    logic          hsync_s1, vsync_s1, active_s1, blank_s1;
    pixel_t        colour;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pix_ce     (i_pix_ce),
        .o_h_pair     (h_pair),
        .o_hsync      (raw_hsync),
        .o_vsync      (raw_vsync),
        .o_active     (raw_active),
        .o_blank_start(raw_blank_start),
        .o_row_adv    (row_adv),
        .o_frame_wrap (frame_wrap)
    );

    // Stage 1: address and delayed sync/active; address holds through blanking.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_base  <= '0;
            fb_addr   <= '0;
            hsync_s1  <= 1'b1;
            vsync_s1  <= 1'b1;
            active_s1 <= 1'b0;
            blank_s1  <= 1'b0;
        end else if (i_pix_ce) begin
            if (raw_active)
                fb_addr <= row_base + fb_addr_t'(h_pair);
            if (frame_wrap)
                row_base <= '0;
            else if (row_adv)
                row_base <= row_base + fb_addr_t'(FB_W);
            hsync_s1  <= raw_hsync;
            vsync_s1  <= raw_vsync;
            active_s1 <= raw_active;
            blank_s1  <= raw_blank_start;
        end
    end

    // Stage 2: colour capture and output sync; frame_done is re-evaluated every clk to stay one clk wide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync      <= 1'b1;
            o_vsync      <= 1'b1;
            o_active     <= 1'b0;
            colour       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= i_pix_ce && blank_s1;
            if (i_pix_ce) begin
                o_hsync  <= hsync_s1;
                o_vsync  <= vsync_s1;
                o_active <= active_s1;
                colour   <= active_s1 ? fb.i_fb_pixel : '0;
            end
        end
    end

    assign fb.o_fb_addr    = fb_addr;
    assign {o_r, o_g, o_b} = colour;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster so several frames fit in a short run.
module tb_vga_scanout;
    import vga_pkg::*;

    localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACT = 8,  V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;

    typedef struct packed {
        logic     hs;
        logic     vs;
        logic     act;
        pixel_t   pix;
        fb_addr_t addr;
        logic     fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic       hsync, vsync, active, frame_done;
    logic [3:0] r, g, b;

    vga_scanout_if fb_bus();

    vga_scanout #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pix_ce    (pix_ce),
        .fb          (fb_bus),
        .o_hsync     (hsync),
        .o_vsync     (vsync),
        .o_r         (r),
        .o_g         (g),
        .o_b         (b),
        .o_active    (active),
        .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Framebuffer model: data for the current address settles within one clk.
    logic force_fff = 1'b0;
    always @(negedge clk)
        fb_bus.i_fb_pixel = force_fff ? 12'hFFF : fb_bus.o_fb_addr[11:0];

    int       n_checks = 0;
    int       n_err = 0;
    int       fd_count = 0;
    exp_t     q[$];
    exp_t     cur;
    fb_addr_t cur_addr = '0;
    logic     ce_prev = 1'b0;
    logic     mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: each pix_ce edge retires one queued expectation; between enables outputs must hold.
    always @(posedge clk) ce_prev <= pix_ce;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ce_prev) begin
                if (q.size() < 2) begin
                    check("scoreboard_depth", q.size(), 2);
                end else begin
                    cur      = q.pop_front();
                    cur_addr = q[0].addr;
                end
            end
            check("video", {hsync, vsync, active, r, g, b}, {cur.hs, cur.vs, cur.act, cur.pix});
            check("fb_addr", fb_bus.o_fb_addr, cur_addr);
            check("frame_done", frame_done, ce_prev && cur.fd);
            if (frame_done) fd_count++;
        end
    end

    // Driver-side raster model.
    int       h = 0;
    int       v = 0;
    fb_addr_t last_addr = '0;

    task automatic issue();
        exp_t e;
        int   a;
        a      = (v / 2) * FB_W + h / 2;
        e.act  = (h < H_ACT) && (v < V_ACT);
        e.hs   = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC));
        e.vs   = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC));
        if (e.act) last_addr = fb_addr_t'(a);
        e.addr = last_addr;
        e.pix  = e.act ? (force_fff ? 12'hFFF : a[11:0]) : 12'h000;
        e.fd   = (h == 0) && (v == V_ACT);
        q.push_back(e);
        h++;
        if (h == H_TOT) begin
            h = 0;
            v = (v == V_TOT - 1) ? 0 : v + 1;
        end
    endtask

    task automatic tick(input logic ce);
        @(posedge clk);
        #1;
        pix_ce = ce;
        if (ce) issue();
    endtask

    task automatic run(input int n_ce, input int gap);
        for (int i = 0; i < n_ce; i++) begin
            tick(1'b1);
            for (int j = 0; j < gap; j++) tick(1'b0);
        end
    endtask

    task automatic restart_model();
        q.delete();
        h         = 0;
        v         = 0;
        last_addr = '0;
        cur.hs    = 1'b1;
        cur.vs    = 1'b1;
        cur.act   = 1'b0;
        cur.pix   = '0;
        cur.addr  = '0;
        cur.fd    = 1'b0;
        cur_addr  = '0;
        q.push_back(cur);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_video"}, {hsync, vsync, active, r, g, b}, {3'b110, 12'h000});
        check({tag, "_fb_addr"}, fb_bus.o_fb_addr, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        restart_model();
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Three frames with pix_ce held high.
        run(3 * FRAME, 0);
        repeat (3) tick(1'b0);
        check("frame_done_count_3_frames", fd_count, 3);

        // Saturated framebuffer data: blanking must still read as black.
        force_fff = 1'b1;
        run(FRAME, 0);
        force_fff = 1'b0;

        // pix_ce one clk in four.
        run(FRAME, 3);
        repeat (3) tick(1'b0);
        check("frame_done_count_5_frames", fd_count, 5);

        // Asynchronous reset in the middle of an active line.
        run(4 * H_TOT + 10, 0);
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset("async_reset");
        restart_model();
        fd_count = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run(FRAME + 2 * H_TOT, 0);
        repeat (3) tick(1'b0);
        check("frame_done_count_after_reset", fd_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1);
    end
endmodule
